// File: rtl/sr_cpu_mc_pkg.sv
// Shared constants for the multi-cycle schoolRISCV core: FSM encodings, opcodes,
// ALU operation codes and the canonical nop used as the reset instruction.
package sr_cpu_mc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_FETCH = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_EXEC  = 2'd2;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_OR   = 3'd1,
        ALU_SRL  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_SUB  = 3'd4
    } alu_op_t;

endpackage

// File: rtl/sr_alu.sv
// Integer ALU for the supported subset: add, or, srl, sltu, sub.
module sr_alu
    import sr_cpu_mc_pkg::*;
(
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  alu_op_t     op,
    output logic        zero,
    output logic [31:0] result
);

    always_comb begin
        case (op)
            ALU_ADD:  result = src_a + src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_SRL:  result = src_a >> src_b[4:0];
            ALU_SLTU: result = {31'b0, (src_a < src_b)};
            ALU_SUB:  result = src_a - src_b;
            default:  result = src_a + src_b;
        endcase
    end

    assign zero = (result == 32'b0);

endmodule

// File: rtl/sr_control.sv
// Main decoder: maps opcode/funct fields to datapath controls and resolves branches.
module sr_control
    import sr_cpu_mc_pkg::*;
(
    input  logic [6:0] cmd_op,
    input  logic [2:0] cmd_f3,
    input  logic [6:0] cmd_f7,
    input  logic       alu_zero,
    output logic       pc_src,
    output logic       reg_write,
    output logic       alu_src,
    output logic       wd_src,
    output alu_op_t    alu_ctrl
);

    logic branch;
    logic cond_zero;

    always_comb begin
        branch    = 1'b0;
        cond_zero = 1'b0;
        reg_write = 1'b0;
        alu_src   = 1'b0;
        wd_src    = 1'b0;
        alu_ctrl  = ALU_ADD;
        case (cmd_op)
            OP_OPIMM: begin
                if (cmd_f3 == 3'b000) begin
                    reg_write = 1'b1;
                    alu_src   = 1'b1;
                end
            end
            OP_OP: begin
                case ({cmd_f7, cmd_f3})
                    {F7_BASE, 3'b000}: begin reg_write = 1'b1; alu_ctrl = ALU_ADD;  end
                    {F7_ALT,  3'b000}: begin reg_write = 1'b1; alu_ctrl = ALU_SUB;  end
                    {F7_BASE, 3'b110}: begin reg_write = 1'b1; alu_ctrl = ALU_OR;   end
                    {F7_BASE, 3'b101}: begin reg_write = 1'b1; alu_ctrl = ALU_SRL;  end
                    {F7_BASE, 3'b011}: begin reg_write = 1'b1; alu_ctrl = ALU_SLTU; end
                    default: ;
                endcase
            end
            OP_LUI: begin
                reg_write = 1'b1;
                wd_src    = 1'b1;
            end
            OP_BRANCH: begin
                // beq wants a zero difference, bne a non-zero one
                alu_ctrl = ALU_SUB;
                if (cmd_f3 == 3'b000) begin
                    branch    = 1'b1;
                    cond_zero = 1'b1;
                end else if (cmd_f3 == 3'b001) begin
                    branch    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign pc_src = branch & (alu_zero == cond_zero);

endmodule

// File: rtl/sr_cpu_mc_fetch.sv
// Fetch sequencer: FETCH/WAIT/EXEC FSM, pc and instruction registers, and the
// single-outstanding request/response handshake to instruction memory.
module sr_cpu_mc_fetch
    import sr_cpu_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IM_ADDR_W = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imReq,
    output logic [IM_ADDR_W-1:0] imAddr,
    input  logic                 imReady,
    input  logic                 imValid,
    input  logic [31:0]          imData,
    input  logic                 pc_src,
    input  logic [31:0]          imm_b,
    output logic [31:0]          pc,
    output logic [31:0]          instr,
    output logic                 exec_en
);

    state_t state;
    state_t state_next;

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: if (imReady) state_next = ST_WAIT;
            ST_WAIT:  if (imValid) state_next = ST_EXEC;
            ST_EXEC:  state_next = ST_FETCH;
            default:  state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
            instr <= NOP_INSTR;
        end else begin
            state <= state_next;
            // responses are only meaningful while a request is outstanding
            if ((state == ST_WAIT) && imValid)
                instr <= imData;
            if (state == ST_EXEC)
                pc <= pc_src ? (pc + imm_b) : (pc + 32'd4);
        end
    end

    // gated by rst so no request leaks out during the reset cycle itself
    assign imReq   = (state == ST_FETCH) && !rst;
    assign imAddr  = pc[IM_ADDR_W+1:2];
    assign exec_en = (state == ST_EXEC) && !rst;

endmodule

// File: rtl/sr_decode.sv
// Instruction field extraction and immediate generation for the RV32I subset.
module sr_decode
    import sr_cpu_mc_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  cmd_op,
    output logic [4:0]  rd,
    output logic [2:0]  cmd_f3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  cmd_f7,
    output logic [31:0] imm_i,
    output logic [31:0] imm_b,
    output logic [31:0] imm_u,
    output logic        noop
);

    assign cmd_op = instr[6:0];
    assign rd     = instr[11:7];
    assign cmd_f3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign cmd_f7 = instr[31:25];

    assign imm_i = {{21{instr[31]}}, instr[30:20]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    assign noop = (instr == NOP_INSTR);

endmodule

// File: rtl/sr_register_file.sv
// 32x32 register file: three async read ports (one for debug), one sync write port; x0 reads 0.
module sr_register_file (
    input  logic        clk,
    input  logic [4:0]  a0,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    output logic [31:0] rd0,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic [31:0] wd3,
    input  logic        we3
);

    logic [31:0] rf [0:31];

    assign rd0 = (a0 != 5'd0) ? rf[a0] : 32'b0;
    assign rd1 = (a1 != 5'd0) ? rf[a1] : 32'b0;
    assign rd2 = (a2 != 5'd0) ? rf[a2] : 32'b0;

    always_ff @(posedge clk) begin
        if (we3 && (a3 != 5'd0))
            rf[a3] <= wd3;
    end

endmodule

// File: rtl/sr_cpu_mc.sv
// Multi-cycle schoolRISCV core: fetch sequencer plus the single-cycle datapath
// blocks, with register writes and retirement counted only in EXEC.
module sr_cpu_mc
    import sr_cpu_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IM_ADDR_W = 30,
    parameter int          CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imReq,
    output logic [IM_ADDR_W-1:0] imAddr,
    input  logic                 imReady,
    input  logic                 imValid,
    input  logic [31:0]          imData,
    input  logic [4:0]           regAddr,
    output logic [31:0]          regData,
    output logic                 noop,
    output logic [CNT_W-1:0]     instret
);

    logic [31:0] pc;
    logic [31:0] instr;
    logic        exec_en;

    logic [6:0]  cmd_op;
    logic [6:0]  cmd_f7;
    logic [2:0]  cmd_f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;

    logic        alu_zero;
    logic        pc_src;
    logic        reg_write;
    logic        alu_src;
    logic        wd_src;
    alu_op_t     alu_ctrl;

    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic [31:0] wd3;

    sr_cpu_mc_fetch #(
        .RESET_PC  (RESET_PC),
        .IM_ADDR_W (IM_ADDR_W)
    ) u_fetch (
        .clk     (clk),
        .rst     (rst),
        .imReq   (imReq),
        .imAddr  (imAddr),
        .imReady (imReady),
        .imValid (imValid),
        .imData  (imData),
        .pc_src  (pc_src),
        .imm_b   (imm_b),
        .pc      (pc),
        .instr   (instr),
        .exec_en (exec_en)
    );

    sr_decode u_decode (
        .instr  (instr),
        .cmd_op (cmd_op),
        .rd     (rd),
        .cmd_f3 (cmd_f3),
        .rs1    (rs1),
        .rs2    (rs2),
        .cmd_f7 (cmd_f7),
        .imm_i  (imm_i),
        .imm_b  (imm_b),
        .imm_u  (imm_u),
        .noop   (noop)
    );

    sr_control u_control (
        .cmd_op    (cmd_op),
        .cmd_f3    (cmd_f3),
        .cmd_f7    (cmd_f7),
        .alu_zero  (alu_zero),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .alu_src   (alu_src),
        .wd_src    (wd_src),
        .alu_ctrl  (alu_ctrl)
    );

    assign src_b = alu_src ? imm_i : rd2;
    assign wd3   = wd_src ? imm_u : alu_result;

    sr_alu u_alu (
        .src_a  (rd1),
        .src_b  (src_b),
        .op     (alu_ctrl),
        .zero   (alu_zero),
        .result (alu_result)
    );

    // the latched instruction is visible in every state, so writes must wait for EXEC
    sr_register_file u_rf (
        .clk (clk),
        .a0  (regAddr),
        .a1  (rs1),
        .a2  (rs2),
        .a3  (rd),
        .rd0 (rd0),
        .rd1 (rd1),
        .rd2 (rd2),
        .wd3 (wd3),
        .we3 (reg_write && exec_en)
    );

    assign regData = (regAddr != 5'd0) ? rd0 : pc;

    always_ff @(posedge clk) begin
        if (rst)
            instret <= '0;
        else if (exec_en)
            instret <= instret + CNT_W'(1);
    end

endmodule

// File: tb/tb_sr_cpu_mc.sv
// Bench for sr_cpu_mc: behavioural instruction memory with configurable stall,
// latency and spurious responses; expected fetch addresses queued per program.
`timescale 1ns/1ps
module tb_sr_cpu_mc;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imReq;
    logic [29:0] imAddr;
    logic        imReady = 1'b0;
    logic        imValid = 1'b0;
    logic [31:0] imData = 32'h0;
    logic [4:0]  regAddr = 5'd0;
    logic [31:0] regData;
    logic        noop;
    logic [31:0] instret;

    sr_cpu_mc #(
        .RESET_PC  (RST_PC),
        .IM_ADDR_W (30),
        .CNT_W     (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .imReq   (imReq),
        .imAddr  (imAddr),
        .imReady (imReady),
        .imValid (imValid),
        .imData  (imData),
        .regAddr (regAddr),
        .regData (regData),
        .noop    (noop),
        .instret (instret)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] imem [0:255];
    logic [29:0] exp_q [$];
    int          latency    = 1;
    int          stall_cfg  = 0;
    int          stall_left = 0;
    int          n_acc      = 0;
    bit          pend       = 1'b0;
    bit          spurious   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [12:0] off);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    // Memory model and fetch monitor: acts 1ns after each falling edge.
    initial begin : imem_model
        int          cnt;
        logic [31:0] resp;
        cnt  = 0;
        resp = NOP;
        forever begin
            @(negedge clk);
            #1;
            imValid = 1'b0;
            imData  = 32'h0;
            imReady = 1'b0;
            if (rst) begin
                pend       = 1'b0;
                stall_left = stall_cfg;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        imValid    = 1'b1;
                        imData     = resp;
                        pend       = 1'b0;
                        stall_left = stall_cfg;
                    end
                end else if (spurious) begin
                    imValid = 1'b1;
                    imData  = NOP;
                end
                if (!pend && imReq) begin
                    if (stall_left > 0) begin
                        stall_left--;
                        if (exp_q.size() > 0)
                            chk("addr_hold", {2'b0, imAddr}, {2'b0, exp_q[0]});
                    end else begin
                        imReady = 1'b1;
                        pend    = 1'b1;
                        cnt     = latency;
                        resp    = imem[imAddr[7:0]];
                        n_acc++;
                        if (exp_q.size() > 0)
                            chk("fetch_addr", {2'b0, imAddr}, {2'b0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic do_reset(input string tag, input int lat, input int stall);
        @(negedge clk);
        rst       = 1'b1;
        regAddr   = 5'd0;
        spurious  = 1'b0;
        latency   = lat;
        stall_cfg = stall;
        exp_q.delete();
        for (int i = 0; i < 256; i++) imem[i] = NOP;
        #2;
        chk({tag, "_imreq_in_rst"}, {31'b0, imReq}, 32'd0);
        @(negedge clk);
        #2;
        chk({tag, "_rst_instret"}, instret, 32'd0);
        chk({tag, "_rst_noop"}, {31'b0, noop}, 32'd1);
        chk({tag, "_rst_pc"}, regData, RST_PC);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        chk({tag, "_fetches_left"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic rchk(input string name, input logic [4:0] idx, input logic [31:0] exp);
        @(negedge clk);
        regAddr = idx;
        #2;
        chk(name, regData, exp);
    endtask

    task automatic pc_chk(input string name, input logic [31:0] exp);
        regAddr = 5'd0;
        #1;
        chk(name, regData, exp);
    endtask

    initial begin : main
        int base;
        bit got;

        // reset state, zero-latency memory, ALU coverage
        do_reset("p1", 1, 0);
        imem[8'h40] = addi(5'd1, 5'd0, 12'd5);
        imem[8'h41] = addi(5'd2, 5'd1, 12'd3);
        imem[8'h42] = lui(5'd3, 20'h12345);
        imem[8'h43] = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd4);
        imem[8'h44] = rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd5);
        imem[8'h45] = rtype(7'h00, 5'd2, 5'd3, 3'b110, 5'd6);
        imem[8'h46] = rtype(7'h00, 5'd1, 5'd3, 3'b101, 5'd7);
        imem[8'h47] = rtype(7'h00, 5'd2, 5'd1, 3'b011, 5'd8);
        imem[8'h48] = rtype(7'h00, 5'd1, 5'd2, 3'b011, 5'd9);
        imem[8'h49] = addi(5'd10, 5'd0, 12'hFFF);
        for (int a = 'h40; a <= 'h4A; a++) exp_q.push_back(30'(a));
        @(negedge clk);
        rst     = 1'b0;
        regAddr = 5'd2;
        #2;
        chk("p1_imreq", {31'b0, imReq}, 32'd1);
        chk("p1_imaddr", {2'b0, imAddr}, 32'h40);
        chk("p1_instret0", instret, 32'd0);
        repeat (6) @(negedge clk);
        #2;
        chk("p1_x2_at_6", regData, 32'd8);
        chk("p1_instret_at_6", instret, 32'd2);
        wait_drain("p1", 100);
        chk("p1_instret", instret, 32'd10);
        pc_chk("p1_pc", 32'h128);
        rchk("p1_x1", 5'd1, 32'd5);
        rchk("p1_x3_lui", 5'd3, 32'h1234_5000);
        rchk("p1_x4_add", 5'd4, 32'd13);
        rchk("p1_x5_sub", 5'd5, 32'hFFFF_FFFD);
        rchk("p1_x6_or", 5'd6, 32'h1234_5008);
        rchk("p1_x7_srl", 5'd7, 32'h0091_A280);
        rchk("p1_x8_sltu", 5'd8, 32'd1);
        rchk("p1_x9_sltu", 5'd9, 32'd0);
        rchk("p1_x10_neg", 5'd10, 32'hFFFF_FFFF);

        // imReady held low, slow response
        do_reset("p2", 3, 4);
        imem[8'h40] = addi(5'd11, 5'd0, 12'd42);
        exp_q.push_back(30'h40);
        exp_q.push_back(30'h41);
        @(negedge clk);
        rst = 1'b0;
        wait_drain("p2", 60);
        chk("p2_instret", instret, 32'd1);
        pc_chk("p2_pc", 32'h104);
        rchk("p2_x11", 5'd11, 32'd42);

        // branches taken and not taken
        do_reset("p3", 1, 0);
        imem[8'h40] = addi(5'd13, 5'd0, 12'd0);
        imem[8'h41] = br(3'b000, 5'd0, 5'd0, 13'h1F04);
        imem[8'h02] = br(3'b000, 5'd13, 5'd0, 13'h1FF8);
        imem[8'h00] = addi(5'd13, 5'd0, 12'd1);
        imem[8'h01] = br(3'b001, 5'd13, 5'd0, 13'h0004);
        imem[8'h03] = br(3'b001, 5'd0, 5'd0, 13'h0040);
        exp_q.push_back(30'h40);
        exp_q.push_back(30'h41);
        exp_q.push_back(30'h02);
        exp_q.push_back(30'h00);
        exp_q.push_back(30'h01);
        exp_q.push_back(30'h02);
        exp_q.push_back(30'h03);
        exp_q.push_back(30'h04);
        @(negedge clk);
        rst = 1'b0;
        wait_drain("p3", 100);
        chk("p3_instret", instret, 32'd7);
        pc_chk("p3_pc", 32'h10);
        rchk("p3_x13", 5'd13, 32'd1);

        // spurious imValid outside WAIT
        do_reset("p4", 2, 0);
        spurious = 1'b1;
        imem[8'h40] = addi(5'd14, 5'd0, 12'd1);
        imem[8'h41] = addi(5'd15, 5'd14, 12'd1);
        imem[8'h42] = addi(5'd16, 5'd0, 12'd3);
        for (int a = 'h40; a <= 'h43; a++) exp_q.push_back(30'(a));
        @(negedge clk);
        rst = 1'b0;
        wait_drain("p4", 100);
        chk("p4_instret", instret, 32'd3);
        chk("p4_noop", {31'b0, noop}, 32'd0);
        pc_chk("p4_pc", 32'h10C);
        rchk("p4_x14", 5'd14, 32'd1);
        rchk("p4_x15", 5'd15, 32'd2);
        rchk("p4_x16", 5'd16, 32'd3);

        // reset while a request is outstanding
        do_reset("p5", 6, 0);
        imem[8'h40] = addi(5'd16, 5'd0, 12'd9);
        exp_q.push_back(30'h40);
        base = n_acc;
        got  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (n_acc > base) begin
                got = 1'b1;
                break;
            end
        end
        chk("p5_accepted", {31'b0, got}, 32'd1);
        rst     = 1'b1;
        latency = 1;
        exp_q.delete();
        exp_q.push_back(30'h40);
        exp_q.push_back(30'h41);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("p5_imreq", {31'b0, imReq}, 32'd1);
        chk("p5_imaddr", {2'b0, imAddr}, 32'h40);
        chk("p5_instret0", instret, 32'd0);
        pc_chk("p5_pc", RST_PC);
        regAddr = 5'd16;
        #1;
        chk("p5_x16_kept", regData, 32'd3);
        wait_drain("p5", 40);
        chk("p5_instret", instret, 32'd1);
        rchk("p5_x16", 5'd16, 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: run exceeded time limit, got %0d compared, required completion", n_cmp);
        $fatal(1, "time limit");
    end

endmodule
